// File: rtl/sfx_arbiter_if.sv
// Bundle between the game-side sound-effect requesters and the Audio tone selector.
// The game logic drives the master side. The arbiter implements the slave side.
interface sfx_arbiter_if #(
  parameter int NREQ = 4
);
  logic                en;
  logic [NREQ-1:0]     req;
  logic [8*NREQ-1:0]   dur;
  logic [2:0]          sel;
  logic [NREQ-1:0]     grant;
  logic                playing;
  logic                done;

  modport master (
    output en, req, dur,
    input  sel, grant, playing, done
  );

  modport slave (
    input  en, req, dur,
    output sel, grant, playing, done
  );
endinterface

// File: rtl/sfx_arbiter.sv
// Fixed-priority, preemptive arbiter that shares one Audio tone generator among sound effects.
// Each grant plays for a timed number of ms. A natural finish is followed by a silent gap.
module sfx_arbiter #(
  parameter int NREQ     = 4,
  parameter int TICK_DIV = 100000,
  parameter int GAP_MS   = 10
) (
  input  logic         clk,
  input  logic         rst,
  sfx_arbiter_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_MS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] req_q, req_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [2:0]      cur_q, cur_d;
  logic [2:0]      sel_q, sel_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      ms_q, ms_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            playing_q, playing_d;
  logic            done_q, done_d;

  logic [NREQ-1:0] rise;
  logic            win_valid;
  logic [2:0]      win_idx;
  logic [7:0]      win_dur;
  logic            tick;
  logic            start;

  // Lowest set pending index wins. Scanning downward lets the last hit be the winner.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_dur   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        win_valid = 1'b1;
        win_idx   = 3'(i);
        win_dur   = bus.dur[8*i +: 8];
      end
    end
  end

  assign tick = (presc_q == PRESC_LAST);

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    req_d     = bus.req;
    rise      = bus.req & ~req_q;
    state_d   = state_q;
    pending_d = pending_q | rise;
    cur_d     = cur_q;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    ms_d      = ms_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    start     = 1'b0;

    if (!bus.en) begin
      state_d   = S_IDLE;
      pending_d = '0;
      cur_d     = '0;
      presc_d   = '0;
      ms_d      = '0;
      gap_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          presc_d = '0;
          start   = win_valid;
        end

        S_PLAY: begin
          // A finishing tick wins over a same-cycle preemption, because the sound has already played out.
          if (tick && ms_q <= 8'd1) begin
            done_d  = 1'b1;
            ms_d    = '0;
            presc_d = '0;
            if (GAP_MS > 0) begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            if (tick) ms_d = ms_q - 8'd1;
            start = win_valid && (win_idx < cur_q);
          end
        end

        S_GAP: begin
          if (tick) begin
            if (gap_q <= GW'(1)) begin
              state_d = S_IDLE;
              gap_d   = '0;
              presc_d = '0;
            end else begin
              gap_d = gap_q - GW'(1);
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          presc_d = '0;
        end
      endcase
    end

    // A grant drops the winner's pending bit. An edge arriving on that same index in this cycle re-arms it.
    if (start) begin
      state_d   = S_PLAY;
      cur_d     = win_idx;
      pending_d = (pending_q & ~(NREQ'(1) << win_idx)) | rise;
      ms_d      = (win_dur == 8'd0) ? 8'd1 : win_dur;
      presc_d   = '0;
    end

    playing_d = (state_d == S_PLAY);
    sel_d     = playing_d ? cur_d + 3'd1 : 3'd0;
    grant_d   = playing_d ? (NREQ'(1) << cur_d) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      cur_q     <= '0;
      sel_q     <= '0;
      presc_q   <= '0;
      ms_q      <= '0;
      gap_q     <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      cur_q     <= cur_d;
      sel_q     <= sel_d;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      gap_q     <= gap_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.grant   = grant_q;
  assign bus.playing = playing_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed self-checking bench for sfx_arbiter with TICK_DIV=4, GAP_MS=2, NREQ=4.
// Outputs are sampled 1 ns after each rising edge. Inputs change at the same point.
module tb_sfx_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sfx_arbiter_if #(.NREQ(4)) bus ();

  sfx_arbiter #(
    .NREQ    (4),
    .TICK_DIV(4),
    .GAP_MS  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected grant and playing values follow from the expected sel code.
  task automatic chk_out(input string tag, input int e_sel, input int e_done);
    int e_grant;
    e_grant = (e_sel == 0) ? 0 : (1 << (e_sel - 1));
    check({tag, ".sel"},     32'(bus.sel),     32'(e_sel));
    check({tag, ".grant"},   32'(bus.grant),   32'(e_grant));
    check({tag, ".playing"}, 32'(bus.playing), (e_sel != 0) ? 32'd1 : 32'd0);
    check({tag, ".done"},    32'(bus.done),    32'(e_done));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic play_check(input string tag, input int s, input int n);
    for (int i = 0; i < n; i++) begin
      chk_out(tag, s, 0);
      step();
    end
  endtask

  task automatic quiet_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk_out(tag, 0, 0);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.en  = 1'b1;
    bus.req = '0;
    bus.dur = '0;
    rst     = 1'b0;
    #12;
    chk_out("reset", 0, 0);
    rst = 1'b1;
    step();
    chk_out("post_reset", 0, 0);

    // Single request: dur2=3 gives 12 cycles of sel=3, then a done pulse and a gap.
    bus.dur[23:16] = 8'd3;
    bus.req[2]     = 1'b1;
    step();
    chk_out("s1_pend", 0, 0);
    step();
    play_check("s1_play", 3, 12);
    chk_out("s1_done", 0, 1);
    bus.req[2] = 1'b0;
    step();
    quiet_check("s1_gap", 8);

    // Simultaneous requests: index 1 first. Index 3 follows after 8 gap cycles and 1 idle cycle.
    bus.dur[15:8]  = 8'd1;
    bus.dur[31:24] = 8'd1;
    bus.req[1]     = 1'b1;
    bus.req[3]     = 1'b1;
    step();
    chk_out("s2_pend", 0, 0);
    step();
    play_check("s2_a", 2, 4);
    chk_out("s2_a_done", 0, 1);
    bus.req = '0;
    step();
    quiet_check("s2_gap", 8);
    play_check("s2_b", 4, 4);
    chk_out("s2_b_done", 0, 1);
    step();
    quiet_check("s2_idle", 9);

    // Preemption: index 0 rises in play cycle 6 of index 3. Index 3 is dropped for good.
    bus.dur[31:24] = 8'd5;
    bus.dur[7:0]   = 8'd2;
    bus.req[3]     = 1'b1;
    step();
    step();
    play_check("s3_low", 4, 5);
    chk_out("s3_low6", 4, 0);
    bus.req[0] = 1'b1;
    step();
    chk_out("s3_low7", 4, 0);
    step();
    play_check("s3_hi", 1, 1);
    bus.dur[7:0] = 8'd9;
    play_check("s3_hi", 1, 7);
    chk_out("s3_hi_done", 0, 1);
    bus.req = '0;
    step();
    quiet_check("s3_noreplay", 20);

    // Re-trigger: a second rise on index 2 during its own play replays it after the gap.
    bus.dur[23:16] = 8'd1;
    bus.req[2]     = 1'b1;
    step();
    step();
    chk_out("s4_p1", 3, 0);
    bus.req[2] = 1'b0;
    step();
    chk_out("s4_p2", 3, 0);
    bus.req[2] = 1'b1;
    step();
    chk_out("s4_p3", 3, 0);
    bus.req[2] = 1'b0;
    step();
    chk_out("s4_p4", 3, 0);
    step();
    chk_out("s4_done", 0, 1);
    step();
    quiet_check("s4_gap", 8);
    play_check("s4_replay", 3, 4);
    chk_out("s4_replay_done", 0, 1);
    step();
    quiet_check("s4_idle", 9);

    // Hold: req[1] held high for about 100 cycles with dur=0 gives exactly one 4-cycle play.
    bus.dur[15:8] = 8'd0;
    bus.req[1]    = 1'b1;
    step();
    step();
    play_check("s5_hold", 2, 4);
    chk_out("s5_done", 0, 1);
    step();
    quiet_check("s5_once", 93);
    bus.req[1] = 1'b0;
    step();

    // en=0 mid-play while pending[3] waits: everything is cleared. Held lines do not fire on re-enable.
    bus.dur[23:16] = 8'd3;
    bus.req[2]     = 1'b1;
    step();
    step();
    play_check("s6_play", 3, 3);
    bus.req[3] = 1'b1;
    step();
    chk_out("s6_nopreempt", 3, 0);
    bus.en = 1'b0;
    step();
    chk_out("s6_off", 0, 0);
    bus.req[0] = 1'b1;
    step();
    quiet_check("s6_off_hold", 3);
    bus.en = 1'b1;
    quiet_check("s6_idle", 20);
    bus.req = '0;
    step();

    // Asynchronous reset mid-play: outputs drop before the next edge. Nothing stale is granted afterwards.
    bus.dur[15:8] = 8'd3;
    bus.req[1]    = 1'b1;
    step();
    step();
    chk_out("s7_play1", 2, 0);
    bus.req[3] = 1'b1;
    step();
    chk_out("s7_play2", 2, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_out("s7_async", 0, 0);
    bus.req = '0;
    step();
    step();
    #2;
    rst = 1'b1;
    step();
    quiet_check("s7_clean", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
